// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hard-wired zero index.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents:
//   CPU_DATA_W  default architectural register width
//   CPU_ADDR_W  default register index width (depth = 2**CPU_ADDR_W)
//   REG_ZERO    index of the register that reads as zero when ZERO_REG=1
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard with a running count of pending registers.
// Latency: busy bits and busy_cnt update one cycle after the issue/write event.
// Backpressure: none; it only reports state, the hazard unit decides to stall.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (clears everything)
//   iss_en, iss_addr    mark iss_addr pending
//   wr_en, wr_addr      writeback completing, clears wr_addr pending
//   busy                one bit per register, 1 = write outstanding
//   busy_cnt            number of set bits in busy, maintained incrementally
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  logic set_v;
  logic clr_v;
  logic same;
  logic inc;
  logic dec;

  // The zero register can never hold a pending write, so neither event
  // touches it; that keeps busy[0] permanently clear.
  always_comb begin
    set_v = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));
    clr_v = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(REG_ZERO)));
    same  = set_v && clr_v && (iss_addr == wr_addr);
    // Count only real transitions of a bit: issuing to an already-busy
    // register adds nothing, and a write that is overridden by a same-cycle
    // issue to the same index removes nothing.
    inc   = set_v && !busy[iss_addr];
    dec   = clr_v && !same && busy[wr_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      // Clear first, set second: a new producer issued in the same cycle as
      // the old one retires keeps the register pending.
      if (clr_v) busy[wr_addr]  <= 1'b0;
      if (set_v) busy[iss_addr] <= 1'b1;
      if (inc && !dec)
        busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, 1'b1};
      else if (dec && !inc)
        busy_cnt <= busy_cnt - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file (NUM_RD reads, 1 write) with write-through bypass and scoreboard.
// Latency: reads 0 cycles (combinational); writes and busy updates land at the next posedge.
// Backpressure: none internally; rd_busy tells the hazard unit which consumers must stall.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (registers, busy bits and count cleared)
//   rd_addr      packed read indices, port p at [p*ADDR_W +: ADDR_W]
//   rd_data      packed read data,    port p at [p*DATA_W +: DATA_W]
//   rd_busy      per-port pending-write flag for the addressed register
//   wr_en/addr/data  writeback port
//   iss_en/addr  long-latency producer issued to iss_addr
//   busy_cnt     number of registers currently pending
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  // Flop array rather than RAM: the async reset has to clear every entry.
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              fwd;

    assign a       = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
    // The completing write both supplies the data and releases the
    // consumer in the same cycle, so ID does not stall an extra cycle.
    assign fwd     = (BYPASS != 0) && wr_en && (wr_addr == a);

    assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 :
                                         fwd     ? wr_data :
                                                   regs[a];
    assign rd_busy[p] = busy[a] & ~fwd;
  end

endmodule
